// File: rtl/alu_md_control.sv
// ALU control decode plus an iterative multiply/divide sequencer that owns HI/LO.
// Optional feature macro ALU_MD_DIVZERO_FAST_EN: divide-by-zero completes one cycle after start.
module alu_md_control #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       funct,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             md_start,
    output logic [2:0]       alu_sel,
    output logic             brk,
    output logic [1:0]       hilo_sel,
    output logic             md_busy,
    output logic             md_done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 negRes_q, negRes_d;
    logic                 negRem_q, negRem_d;
    logic                 isDiv_q, isDiv_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 startReq;
    logic                 isSigned;
    logic                 isDivOp;
    logic                 bZero;
    logic [WIDTH-1:0]     aMag;
    logic [WIDTH-1:0]     bMag;
    logic [WIDTH:0]       mulSum;
    logic [WIDTH:0]       divTrial;
    logic [2*WIDTH-1:0]   fixProd;
    logic [WIDTH-1:0]     fixQuo;
    logic [WIDTH-1:0]     fixRem;

    always_comb begin
        alu_sel  = 3'b001;
        hilo_sel = 2'b00;
        case (alu_op)
            3'b000: alu_sel = 3'b001;
            3'b001: alu_sel = 3'b010;
            3'b011: alu_sel = 3'b011;
            3'b100: alu_sel = 3'b100;
            3'b101: alu_sel = 3'b111;
            3'b010: begin
                case (funct)
                    6'h20, 6'h21: alu_sel = 3'b001;
                    6'h22, 6'h23: alu_sel = 3'b010;
                    6'h24:        alu_sel = 3'b011;
                    6'h25:        alu_sel = 3'b100;
                    6'h26:        alu_sel = 3'b110;
                    6'h27:        alu_sel = 3'b101;
                    6'h2a:        alu_sel = 3'b111;
                    default:      alu_sel = 3'b000;
                endcase
                if (funct == 6'h10) hilo_sel = 2'b01;
                if (funct == 6'h12) hilo_sel = 2'b10;
            end
            default: alu_sel = 3'b001;
        endcase
    end

    assign brk = (funct == 6'h0d);

    // funct 18..1b: bit0 selects unsigned, bit1 selects divide
    assign startReq = md_start && (alu_op == 3'b010) && (funct[5:2] == 4'b0110);
    assign isSigned = ~funct[0];
    assign isDivOp  = funct[1];
    assign bZero    = (op_b == '0);
    assign aMag     = (isSigned && op_a[WIDTH-1]) ? -op_a : op_a;
    assign bMag     = (isSigned && op_b[WIDTH-1]) ? -op_b : op_b;

    assign mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    assign divTrial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_q};

    assign fixProd  = negRes_q ? -acc_q : acc_q;
    assign fixQuo   = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign fixRem   = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    // Sequencer: accumulator holds {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        dvs_d    = dvs_q;
        negRes_d = negRes_q;
        negRem_d = negRem_q;
        isDiv_d  = isDiv_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (startReq) begin
                    cnt_d    = CNT_INIT;
                    acc_d    = {{WIDTH{1'b0}}, aMag};
                    dvs_d    = bMag;
                    negRes_d = isSigned && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    negRem_d = isSigned && op_a[WIDTH-1];
                    isDiv_d  = isDivOp;
                    dz_d     = isDivOp && bZero;
                    if (!isDivOp)
                        state_d = S_MUL;
`ifdef ALU_MD_DIVZERO_FAST_EN
                    else if (bZero)
                        state_d = S_DONE;
`endif
                    else
                        state_d = S_DIV;
                end
            end
            S_MUL: begin
                acc_d = {mulSum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_DIV: begin
                if (!divTrial[WIDTH])
                    acc_d = {divTrial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else
                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (!dz_q) begin
                    if (isDiv_q) begin
                        hi_d = fixRem;
                        lo_d = fixQuo;
                    end else begin
                        hi_d = fixProd[2*WIDTH-1:WIDTH];
                        lo_d = fixProd[WIDTH-1:0];
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            dvs_q    <= '0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
            isDiv_q  <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            dvs_q    <= dvs_d;
            negRes_q <= negRes_d;
            negRem_q <= negRem_d;
            isDiv_q  <= isDiv_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign md_busy  = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign md_done  = (state_q == S_DONE);
    assign div_zero = (state_q == S_DONE) && dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_alu_md_control.sv
// Scoreboard bench for alu_md_control: a 32-bit and an 8-bit instance checked against
// an arithmetic reference model; a monitor pops expected results whenever md_done rises.
module tb_alu_md_control;
    localparam int W0 = 32;
    localparam int W1 = 8;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        bit          dz;
        int          startCyc;
        int          doneCyc;
        bit          busyExp;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [5:0]  funct0, funct1;
    logic [2:0]  aluOp0, aluOp1;
    logic [31:0] opA0, opB0;
    logic [7:0]  opA1, opB1;
    logic        mdStart0, mdStart1;
    logic [2:0]  aluSel0, aluSel1;
    logic        brk0, brk1;
    logic [1:0]  hiloSel0, hiloSel1;
    logic        busy0, busy1, done0, done1, dz0, dz1;
    logic [31:0] hi0, lo0;
    logic [7:0]  hi1, lo1;

    int          tests = 0;
    int          fails = 0;
    int          cycleCnt = 0;
    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] refHi[2];
    logic [31:0] refLo[2];
    logic [31:0] curHi[2];
    logic [31:0] curLo[2];

    alu_md_control #(.WIDTH(W0)) dut0 (
        .clk(clk), .reset_n(reset_n), .funct(funct0), .alu_op(aluOp0),
        .op_a(opA0), .op_b(opB0), .md_start(mdStart0), .alu_sel(aluSel0),
        .brk(brk0), .hilo_sel(hiloSel0), .md_busy(busy0), .md_done(done0),
        .div_zero(dz0), .hi(hi0), .lo(lo0)
    );

    alu_md_control #(.WIDTH(W1)) dut1 (
        .clk(clk), .reset_n(reset_n), .funct(funct1), .alu_op(aluOp1),
        .op_a(opA1), .op_b(opB1), .md_start(mdStart1), .alu_sel(aluSel1),
        .brk(brk1), .hilo_sel(hiloSel1), .md_busy(busy1), .md_done(done1),
        .div_zero(dz1), .hi(hi1), .lo(lo1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Reference decode taken straight from the ALUOp/funct tables
    function automatic logic [2:0] refAluSel(input logic [2:0] op, input logic [5:0] f);
        case (op)
            3'd0: return 3'b001;
            3'd1: return 3'b010;
            3'd3: return 3'b011;
            3'd4: return 3'b100;
            3'd5: return 3'b111;
            3'd2: begin
                case (f)
                    6'h20, 6'h21: return 3'b001;
                    6'h22, 6'h23: return 3'b010;
                    6'h24: return 3'b011;
                    6'h25: return 3'b100;
                    6'h26: return 3'b110;
                    6'h27: return 3'b101;
                    6'h2a: return 3'b111;
                    default: return 3'b000;
                endcase
            end
            default: return 3'b001;
        endcase
    endfunction

    function automatic logic [1:0] refHiloSel(input logic [2:0] op, input logic [5:0] f);
        if (op != 3'b010) return 2'b00;
        if (f == 6'h10) return 2'b01;
        if (f == 6'h12) return 2'b10;
        return 2'b00;
    endfunction

    // Multiply/divide on w-bit operands using plain integer arithmetic
    function automatic void mdModel(input int w, input logic [5:0] f, input logic [31:0] a, b,
                                    input logic [31:0] hiIn, loIn,
                                    output logic [31:0] hiOut, loOut, output bit dz);
        logic [63:0] mask, ua, ub, p;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'b0, a} & mask;
        ub = {32'b0, b} & mask;
        sa = ua[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
        sb = ub[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
        hiOut = hiIn;
        loOut = loIn;
        dz = 1'b0;
        case (f)
            6'h18: begin
                p = 64'(sa * sb);
                hiOut = 32'((p >> w) & mask);
                loOut = 32'(p & mask);
            end
            6'h19: begin
                p = ua * ub;
                hiOut = 32'((p >> w) & mask);
                loOut = 32'(p & mask);
            end
            6'h1a: begin
                if (ub == 64'd0) dz = 1'b1;
                else begin
                    hiOut = 32'(64'(sa % sb) & mask);
                    loOut = 32'(64'(sa / sb) & mask);
                end
            end
            6'h1b: begin
                if (ub == 64'd0) dz = 1'b1;
                else begin
                    hiOut = 32'((ua % ub) & mask);
                    loOut = 32'((ua / ub) & mask);
                end
            end
            default: ;
        endcase
    endfunction

    task automatic drive(input int which, input logic [5:0] f, input logic [2:0] op,
                         input logic [31:0] a, b, input logic s);
        if (which == 0) begin
            funct0 = f; aluOp0 = op; opA0 = a; opB0 = b; mdStart0 = s;
        end else begin
            funct1 = f; aluOp1 = op; opA1 = a[7:0]; opB1 = b[7:0]; mdStart1 = s;
        end
    endtask

    function automatic int pending(input int which);
        return (which == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic void sampleDut(input int which, output logic busy, done, dzv,
                                      output logic [31:0] h, l);
        if (which == 0) begin
            busy = busy0; done = done0; dzv = dz0; h = hi0; l = lo0;
        end else begin
            busy = busy1; done = done1; dzv = dz1; h = {24'b0, hi1}; l = {24'b0, lo1};
        end
    endfunction

    // Issue one md_start pulse and push the predicted completion
    task automatic applyStimulus(input int which, input logic [5:0] f, input logic [31:0] a, b);
        exp_t        e;
        logic [31:0] hO, lO;
        bit          dz;
        int          w;
        w = (which == 0) ? W0 : W1;
        @(negedge clk);
        drive(which, f, 3'b010, a, b, 1'b1);
        mdModel(w, f, a, b, refHi[which], refLo[which], hO, lO, dz);
        e.hi       = hO;
        e.lo       = lO;
        e.dz       = dz;
        e.startCyc = cycleCnt + 1;
        e.busyExp  = 1'b1;
        e.doneCyc  = e.startCyc + w + 1;
`ifdef ALU_MD_DIVZERO_FAST_EN
        if (dz) begin
            e.busyExp = 1'b0;
            e.doneCyc = e.startCyc;
        end
`endif
        if (which == 0) sb0.push_back(e); else sb1.push_back(e);
        refHi[which] = hO;
        refLo[which] = lO;
        @(negedge clk);
        if (which == 0) mdStart0 = 1'b0; else mdStart1 = 1'b0;
    endtask

    // md_start pulse that the sequencer must ignore
    task automatic pulseIgnored(input int which, input logic [5:0] f, input logic [2:0] op,
                                input logic [31:0] a, b);
        @(negedge clk);
        drive(which, f, op, a, b, 1'b1);
        @(negedge clk);
        drive(which, f, op, a, b, 1'b0);
    endtask

    task automatic waitIdle(input int which);
        int n;
        n = 0;
        while (pending(which) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checkOutput($sformatf("dut%0d outstanding results", which), 64'(pending(which)), 64'd0);
        if (which == 0) sb0.delete(); else sb1.delete();
        @(posedge clk);
    endtask

    task automatic applyDecode(input logic [2:0] op, input logic [5:0] f);
        @(negedge clk);
        drive(0, f, op, 32'h0, 32'h0, 1'b0);
        drive(1, f, op, 32'h0, 32'h0, 1'b0);
        #1;
        checkOutput($sformatf("alu_sel op=%0h f=%0h", op, f), 64'(aluSel0), 64'(refAluSel(op, f)));
        checkOutput($sformatf("brk f=%0h", f), 64'(brk0), 64'(f == 6'h0d));
        checkOutput($sformatf("hilo_sel op=%0h f=%0h", op, f), 64'(hiloSel0), 64'(refHiloSel(op, f)));
        checkOutput($sformatf("w8 alu_sel op=%0h f=%0h", op, f), 64'(aluSel1), 64'(refAluSel(op, f)));
        checkOutput($sformatf("w8 brk f=%0h", f), 64'(brk1), 64'(f == 6'h0d));
        checkOutput($sformatf("w8 hilo_sel op=%0h f=%0h", op, f), 64'(hiloSel1), 64'(refHiloSel(op, f)));
    endtask

    function automatic logic [31:0] randOperand(input int w);
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1 << (w - 1);
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            default: return $urandom();
        endcase
    endfunction

    // Monitor: compare on md_done, otherwise check busy, div_zero and HI/LO stability
    task automatic monitorStep(input int which);
        logic        busy, done, dzv;
        logic [31:0] h, l;
        exp_t        e;
        bit          expBusy;
        sampleDut(which, busy, done, dzv, h, l);
        if (done) begin
            if (pending(which) == 0) begin
                checkOutput($sformatf("dut%0d unexpected md_done", which), 64'(done), 64'd0);
            end else begin
                if (which == 0) e = sb0.pop_front(); else e = sb1.pop_front();
                checkOutput($sformatf("dut%0d done cycle", which), 64'(cycleCnt), 64'(e.doneCyc));
                checkOutput($sformatf("dut%0d hi", which), 64'(h), 64'(e.hi));
                checkOutput($sformatf("dut%0d lo", which), 64'(l), 64'(e.lo));
                checkOutput($sformatf("dut%0d div_zero", which), 64'(dzv), 64'(e.dz));
                checkOutput($sformatf("dut%0d busy in done", which), 64'(busy), 64'd0);
                curHi[which] = e.hi;
                curLo[which] = e.lo;
            end
        end else begin
            checkOutput($sformatf("dut%0d div_zero idle", which), 64'(dzv), 64'd0);
            checkOutput($sformatf("dut%0d hi stable", which), 64'(h), 64'(curHi[which]));
            checkOutput($sformatf("dut%0d lo stable", which), 64'(l), 64'(curLo[which]));
            expBusy = 1'b0;
            if (pending(which) != 0) begin
                if (which == 0) e = sb0[0]; else e = sb1[0];
                expBusy = e.busyExp && (cycleCnt >= e.startCyc) && (cycleCnt < e.doneCyc);
            end
            checkOutput($sformatf("dut%0d md_busy cyc %0d", which, cycleCnt), 64'(busy), 64'(expBusy));
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            monitorStep(0);
            monitorStep(1);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [5:0] fl [12];
        fl = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h0d, 6'h10, 6'h12};
        for (int i = 0; i < 2; i++) begin
            refHi[i] = '0; refLo[i] = '0; curHi[i] = '0; curLo[i] = '0;
        end
        drive(0, 6'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        drive(1, 6'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        #12;
        checkOutput("reset hi", 64'(hi0), 64'd0);
        checkOutput("reset lo", 64'(lo0), 64'd0);
        checkOutput("reset md_busy", 64'(busy0), 64'd0);
        checkOutput("reset md_done", 64'(done0), 64'd0);
        checkOutput("reset div_zero", 64'(dz0), 64'd0);
        checkOutput("w8 reset hi/lo", 64'({hi1, lo1}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        applyDecode(3'b010, 6'h25);
        applyDecode(3'b010, 6'h27);
        applyDecode(3'b010, 6'h2a);
        applyDecode(3'b010, 6'h0d);
        applyDecode(3'b101, 6'h00);
        applyDecode(3'b010, 6'h10);
        applyDecode(3'b010, 6'h12);
        applyDecode(3'b000, 6'h10);
        for (int i = 0; i < 30; i++) begin
            logic [5:0] f;
            f = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63)) : fl[$urandom_range(0, 11)];
            applyDecode(3'($urandom_range(0, 7)), f);
        end

        // MULT -3 x 7 with a foreign md_start pulse during iteration
        applyStimulus(0, 6'h18, 32'hFFFF_FFFD, 32'd7);
        repeat (3) @(negedge clk);
        drive(0, 6'h1b, 3'b010, 32'd100, 32'd7, 1'b1);
        @(negedge clk);
        drive(0, 6'h1b, 3'b010, 32'd100, 32'd7, 1'b0);
        waitIdle(0);
        checkOutput("MULT -3*7 hi", 64'(hi0), 64'hFFFF_FFFF);
        checkOutput("MULT -3*7 lo", 64'(lo0), 64'hFFFF_FFEB);

        applyStimulus(0, 6'h1b, 32'd100, 32'd7);
        waitIdle(0);
        checkOutput("DIVU 100/7 lo", 64'(lo0), 64'd14);
        checkOutput("DIVU 100/7 hi", 64'(hi0), 64'd2);

        applyStimulus(0, 6'h1a, 32'hFFFF_FF9C, 32'd7);
        waitIdle(0);
        checkOutput("DIV -100/7 lo", 64'(lo0), 64'hFFFF_FFF2);
        checkOutput("DIV -100/7 hi", 64'(hi0), 64'hFFFF_FFFE);

        applyStimulus(0, 6'h19, 32'd5, 32'd5);
        waitIdle(0);
        applyStimulus(0, 6'h1a, 32'd1234, 32'd0);
        waitIdle(0);
        checkOutput("div0 hi kept", 64'(hi0), 64'd0);
        checkOutput("div0 lo kept", 64'(lo0), 64'd25);

        applyStimulus(0, 6'h1a, 32'h8000_0000, 32'hFFFF_FFFF);
        waitIdle(0);
        checkOutput("DIV overflow lo", 64'(lo0), 64'h8000_0000);
        checkOutput("DIV overflow hi", 64'(hi0), 64'd0);

        pulseIgnored(0, 6'h20, 3'b010, 32'd3, 32'd4);
        pulseIgnored(0, 6'h18, 3'b000, 32'd3, 32'd4);
        pulseIgnored(1, 6'h19, 3'b011, 32'd3, 32'd4);
        repeat (40) @(negedge clk);

        applyStimulus(1, 6'h19, 32'hFF, 32'hFF);
        waitIdle(1);
        checkOutput("w8 MULTU FF*FF hi", 64'(hi1), 64'hFE);
        checkOutput("w8 MULTU FF*FF lo", 64'(lo1), 64'h01);

        for (int i = 0; i < 40; i++) begin
            int          which;
            logic [31:0] a, b;
            which = i % 2;
            a = randOperand(which == 0 ? W0 : W1);
            b = randOperand(which == 0 ? W0 : W1);
            applyStimulus(which, 6'h18 + 6'($urandom_range(0, 3)), a, b);
            waitIdle(which);
        end

        // Abort a MULT at cycle 10 with reset
        applyStimulus(0, 6'h18, 32'hFFFF_FFFD, 32'd7);
        waitIdle(0);
        applyStimulus(0, 6'h18, 32'h1234_5678, 32'h9ABC_DEF1);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("abort md_busy", 64'(busy0), 64'd0);
        checkOutput("abort md_done", 64'(done0), 64'd0);
        checkOutput("abort div_zero", 64'(dz0), 64'd0);
        checkOutput("abort hi", 64'(hi0), 64'd0);
        checkOutput("abort lo", 64'(lo0), 64'd0);
        sb0.delete();
        sb1.delete();
        for (int i = 0; i < 2; i++) begin
            refHi[i] = '0; refLo[i] = '0; curHi[i] = '0; curLo[i] = '0;
        end
        drive(0, 6'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (45) @(negedge clk);
        checkOutput("post-abort hi", 64'(hi0), 64'd0);
        checkOutput("post-abort lo", 64'(lo0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_md_control.md
Name: alu_md_control

Overview:
- Next-generation ALU control for the multicycle MIPS datapath.
- Extends the funct/ALUOp decode with OR, NOR and SLT.
- Adds an iterative multiply/divide sequencer (MULT, MULTU, DIV, DIVU) that owns the HI/LO registers and exposes a start/busy/done handshake to the main control FSM.
- Sits beside the ALU; the control FSM stalls in its execute state while md_busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width; any value ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- funct  in  6  instruction funct field
- alu_op  in  3  ALUOp from control FSM
- op_a  in  WIDTH  rs operand
- op_b  in  WIDTH  rt operand
- md_start  in  1  request pulse from control FSM
- alu_sel  out  3  ALU operation select
- brk  out  1  BREAK decoded
- hilo_sel  out  2  00 none, 01 MFHI, 10 MFLO
- md_busy  out  1  sequencer iterating
- md_done  out  1  one-cycle completion pulse
- div_zero  out  1  divide-by-zero flag, valid with md_done
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Combinational decode, no latency:
  - alu_op 000 → 001 (add); 001 → 010 (sub); 011 → 011 (and); 100 → 100 (or); 101 → 111 (slt); others → 001.
  - alu_op 010 decodes funct: 20/21 → 001; 22/23 → 010; 24 → 011; 25 → 100; 26 → 110; 27 → 101; 2a → 111; other → 000 (pass A).
  - brk = (funct == 6'h0d), independent of alu_op.
  - hilo_sel = 01 for funct 10 and 10 for funct 12, only when alu_op == 010; otherwise 00.
- Sequencer states: IDLE, MUL, DIV, FIX, DONE.
- Start condition: IDLE, md_start = 1, alu_op = 010, funct ∈ {18, 19, 1a, 1b}. md_start in any other state, or with any other funct, is ignored.
- On the start edge:
  - Capture operand magnitudes (two's-complement absolute value for signed 18/1a; raw values for 19/1b).
  - Capture result signs; load counter = WIDTH.
  - Go to MUL (18/19) or DIV (1a/1b).
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH product accumulator.
- DIV: restoring, one quotient bit per cycle.
- Counter decrements each cycle in MUL and DIV; at counter == 1, go to FIX.
- FIX (one cycle):
  - Apply sign correction. Product is negated if the operand signs differ. Quotient is negated if the signs differ; remainder takes the sign of op_a.
  - Write HI/LO on exit: MULT gives HI = upper half, LO = lower half; DIV gives HI = remainder, LO = quotient.
- DONE: md_done = 1 for exactly one cycle; then return to IDLE.
- md_busy = 1 in MUL, DIV and FIX; 0 in IDLE and DONE.
- Latency: md_done is asserted exactly WIDTH+2 cycles after the start edge.
- HI/LO change only on the FIX→DONE edge; they are stable at all other times, including during iteration.
- Divide by zero (op_b == 0 on a DIV start):
  - HI and LO remain unchanged.
  - div_zero = 1 during the DONE cycle, 0 otherwise.
  - Timing depends on the optional feature.
- Reset (asynchronous, any state, including mid-operation): state = IDLE, hi = 0, lo = 0, md_busy = 0, md_done = 0, div_zero = 0, counter and accumulators = 0. An aborted operation never writes HI/LO.
- Signed overflow (e.g. DIV of the most negative value by −1): the result wraps; no flag.

Optional Feature:
- Macro: ALU_MD_DIVZERO_FAST_EN.
- Defined: a DIV start with op_b == 0 goes from IDLE directly to DONE, so md_done and div_zero are asserted 1 cycle after the start edge and md_busy never rises.
- Not defined: a divide by zero runs the full WIDTH+2 latency through DIV and FIX, with HI/LO write suppressed and div_zero asserted in DONE.

Test Plan:
- Decode sweep: alu_op = 010, funct = 25/27/2a/0d → alu_sel = 100/101/111; for 0d, alu_sel = 000 and brk = 1. alu_op = 101 → alu_sel = 111.
- MULT, WIDTH = 32: op_a = 0xFFFFFFFD (−3), op_b = 7 → md_done at cycle 34 after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; md_busy high for cycles 1–33.
- DIVU: op_a = 100, op_b = 7 → lo = 14, hi = 2. DIV: op_a = −100, op_b = 7 → lo = −14 (0xFFFFFFF2), hi = −2 (0xFFFFFFFE).
- Divide by zero: preload hi/lo with MULTU 5×5 (hi = 0, lo = 25), then DIV op_b = 0 → div_zero = 1 with md_done; hi = 0, lo = 25. Done arrives at cycle 1 with the macro, cycle 34 without.
- Mid-operation reset: drop reset_n at cycle 10 of a MULT → all outputs 0 immediately; after release, hi = lo = 0 and no md_done appears.
- Handshake: md_start pulsed during MUL with a different funct → ignored; the original result and timing are unchanged. Repeat at WIDTH = 8 with MULTU 0xFF × 0xFF → hi = 0xFE, lo = 0x01, md_done at cycle 10.
